writeback_unit_way0: RTL and testbench
======================================

Name: writeback_unit_way0

Overview:
- Write-back stage for way0. Consumes the registered execute-stage result: rd write enable, rd address, rd data, pipeline ID, valid.
- Buffers results in a small in-order FIFO, drives the RegFile write port, and retires instructions in order.
- Provides a forwarding lookup into pending writes and checks pipeline-ID sequencing.
- Sits directly downstream of the EU register stage; its ready_o drives that stage's ready input.

Parameters:
DATA_W, 64, rd data width
ADDR_W, 5, register address width
PID_W, 2, pipeline ID width
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock
reset_n  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk
valid_i  input  1  EU register holds a result
ready_o  output  1  block can accept a result this cycle
rdWriteEnable_i  input  1  result writes a register
rdAddr_i  input  ADDR_W  destination register
rdData_i  input  DATA_W  result data
way0_pID_i  input  PID_W  pipeline ID of result
wbWriteEnable_o  output  1  RegFile write strobe
wbAddr_o  output  ADDR_W  RegFile write address
wbData_o  output  DATA_W  RegFile write data
wbReady_i  input  1  RegFile port grants write this cycle
fwdAddr_i  input  ADDR_W  forwarding query address
fwdHit_o  output  1  pending buffered write to fwdAddr_i exists
fwdData_o  output  DATA_W  data of youngest matching pending write
retireValid_o  output  1  head entry retires this cycle
retirePID_o  output  PID_W  pID of retiring entry
retireCount_o  output  32  total retired instructions
pidError_o  output  1  sticky: out-of-sequence pID seen

Behaviour:
- Reset (reset_n=1 at clk edge): FIFO empty, read/write pointers 0, expected pID 0, retireCount_o=0, pidError_o=0.
- After reset, combinational outputs take their empty-state values: ready_o=1, wbWriteEnable_o=0, retireValid_o=0, fwdHit_o=0, and wbAddr_o/wbData_o/fwdData_o/retirePID_o = 0.
- Reset asserted mid-operation discards all buffered entries. No write is issued in the reset cycle.
- Accept: push on the clk edge where valid_i && ready_o.
  - ready_o = !full. It does not look at same-cycle pop, so a full FIFO deasserts ready even while draining.
- Head "needs port" = rdWriteEnable && rdAddr != 0.
  - wbWriteEnable_o = !empty && needs port. wbAddr_o/wbData_o = head fields when !empty, else 0.
- Pop / retire: retireValid_o = !empty && (!needs port || wbReady_i). Pop on that edge.
  - Entries that do not need the port (no write, or x0) retire in one cycle without consulting wbReady_i.
  - retirePID_o = head pID when !empty, else 0.
- Latency: result accepted at edge N is head at N+1. It writes and retires at edge N+1 if wbReady_i=1. Minimum one cycle; throughput one per cycle.
- Push and pop on the same edge (not full): occupancy unchanged, pointers both advance, wrap modulo DEPTH.
- retireCount_o increments by 1 per pop and wraps 0xFFFFFFFF -> 0.
- pID check: on each accept, compare way0_pID_i with the expected pID.
  - Mismatch sets pidError_o (held until reset). The entry is still accepted.
  - The expected pID becomes way0_pID_i+1 mod 2^PID_W, i.e. it resynchronises.
- Forwarding (combinational): among valid entries with rdWriteEnable=1, rdAddr == fwdAddr_i and rdAddr != 0, select the youngest (closest to the write pointer).
  - fwdHit_o=1 and fwdData_o = its data. Otherwise fwdHit_o=0, fwdData_o=0.
  - Includes the head even while it is being written. Excludes the incoming valid_i result.

Optional Feature:
WB_PERF_EN:
- Defined: adds output portStallCount_o (32 bits), reset 0, wrapping.
  - Increments each cycle with !empty && needs port && !wbReady_i.
- Undefined: port and counter absent. No other behaviour changes.

Test Plan:
- Reset, then single result rd=5, data=0x1234, pID=0, wbReady_i=1 -> write on the next cycle with wbAddr_o=5, wbData_o=0x1234; retireCount_o=1; pidError_o=0.
- wbReady_i=0 with three back-to-back results, DEPTH=2 -> ready_o=0 after 2 accepts, third held. Raise wbReady_i -> writes occur in order, one per cycle, retireCount_o=3.
- Result with rd=0, rdWriteEnable_i=1 while wbReady_i=0 -> retires in one cycle, wbWriteEnable_o never asserted.
- Buffer writes x7=0xA then x7=0xB (stalled), fwdAddr_i=7 -> fwdHit_o=1, fwdData_o=0xB. fwdAddr_i=0 -> fwdHit_o=0.
- pID sequence 0,1,3,0 -> pidError_o rises after the 3 is accepted and stays 1. The following 0 (expected after 3) does not re-error; pidError_o clears only on reset.
- Preload retireCount_o near wrap by running 2^32-1 retires (or force the counter), retire one more -> 0. Assert reset with 2 entries buffered -> empty and counters 0 next cycle, no write issued.

Source files
------------

// File: rtl/writeback_unit_way0.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_way0
// Description : Way0 write-back stage. Holds results in an in-order FIFO,
//               drives the RegFile write port, retires in order, offers a
//               forwarding lookup and checks pipeline-ID sequencing.
//               Optional macro WB_PERF_EN adds portStallCount_o.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit_way0 #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int PID_W  = 2,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              rdWriteEnable_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    input  logic [DATA_W-1:0] rdData_i,
    input  logic [PID_W-1:0]  way0_pID_i,
    output logic              wbWriteEnable_o,
    output logic [ADDR_W-1:0] wbAddr_o,
    output logic [DATA_W-1:0] wbData_o,
    input  logic              wbReady_i,
    input  logic [ADDR_W-1:0] fwdAddr_i,
    output logic              fwdHit_o,
    output logic [DATA_W-1:0] fwdData_o,
    output logic              retireValid_o,
    output logic [PID_W-1:0]  retirePID_o,
    output logic [31:0]       retireCount_o,
    output logic              pidError_o
`ifdef WB_PERF_EN
    ,
    output logic [31:0]       portStallCount_o
`endif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    logic              r_we   [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PID_W-1:0]  r_pid  [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [PID_W-1:0]   r_exp_pid;
    logic [31:0]        r_retire_cnt;
    logic               r_pid_err;

    logic w_in_reset;
    logic w_empty;
    logic w_full;
    logic w_head_needs;
    logic w_push;
    logic w_pop;

    // reset_n is active-high despite its name
    assign w_in_reset   = reset_n;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_head_needs = r_we[r_rd_ptr] && (r_addr[r_rd_ptr] != '0);

    assign ready_o         = !w_full;
    assign w_push          = valid_i && ready_o;
    assign wbWriteEnable_o = !w_in_reset && !w_empty && w_head_needs;
    assign retireValid_o   = !w_in_reset && !w_empty && (!w_head_needs || wbReady_i);
    assign w_pop           = retireValid_o;

    assign wbAddr_o      = w_empty ? '0 : r_addr[r_rd_ptr];
    assign wbData_o      = w_empty ? '0 : r_data[r_rd_ptr];
    assign retirePID_o   = w_empty ? '0 : r_pid[r_rd_ptr];
    assign retireCount_o = r_retire_cnt;
    assign pidError_o    = r_pid_err;

    // Payload storage carries no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we[r_wr_ptr]   <= rdWriteEnable_i;
            r_addr[r_wr_ptr] <= rdAddr_i;
            r_data[r_wr_ptr] <= rdData_i;
            r_pid[r_wr_ptr]  <= way0_pID_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_exp_pid    <= '0;
            r_retire_cnt <= '0;
            r_pid_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Mismatch is flagged but the expected ID resynchronises to the new one
            if (w_push) begin
                if (way0_pID_i != r_exp_pid) begin
                    r_pid_err <= 1'b1;
                end
                r_exp_pid <= way0_pID_i + PID_W'(1);
            end
        end
    end

    // Per-age match: age 0 is the head, age DEPTH-1 the youngest possible
    logic [c_PTR_W-1:0] w_slot  [DEPTH];
    logic               w_match [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
        assign w_slot[g]  = r_rd_ptr + c_PTR_W'(g);
        assign w_match[g] = (c_CNT_W'(g) < r_count) && r_we[w_slot[g]] &&
                            (r_addr[w_slot[g]] == fwdAddr_i) && (fwdAddr_i != '0);
    end

    always_comb begin
        fwdHit_o  = 1'b0;
        fwdData_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                fwdHit_o  = 1'b1;
                fwdData_o = r_data[w_slot[i]];
            end
        end
    end

`ifdef WB_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            r_stall_cnt <= '0;
        end else if (!w_empty && w_head_needs && !wbReady_i) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign portStallCount_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit_way0.sv
`default_nettype none
// Bench for writeback_unit_way0: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_writeback_unit_way0;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        rdWriteEnable_i = 1'b0;
    logic [4:0]  rdAddr_i = '0;
    logic [63:0] rdData_i = '0;
    logic [1:0]  way0_pID_i = '0;
    logic        wbWriteEnable_o;
    logic [4:0]  wbAddr_o;
    logic [63:0] wbData_o;
    logic        wbReady_i = 1'b0;
    logic [4:0]  fwdAddr_i = '0;
    logic        fwdHit_o;
    logic [63:0] fwdData_o;
    logic        retireValid_o;
    logic [1:0]  retirePID_o;
    logic [31:0] retireCount_o;
    logic        pidError_o;

    writeback_unit_way0 #(.DATA_W(64), .ADDR_W(5), .PID_W(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
        .rdWriteEnable_i(rdWriteEnable_i), .rdAddr_i(rdAddr_i), .rdData_i(rdData_i),
        .way0_pID_i(way0_pID_i), .wbWriteEnable_o(wbWriteEnable_o), .wbAddr_o(wbAddr_o),
        .wbData_o(wbData_o), .wbReady_i(wbReady_i), .fwdAddr_i(fwdAddr_i),
        .fwdHit_o(fwdHit_o), .fwdData_o(fwdData_o), .retireValid_o(retireValid_o),
        .retirePID_o(retirePID_o), .retireCount_o(retireCount_o), .pidError_o(pidError_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [1:0]  pid;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_cnt = '0;
    logic        m_err = 1'b0;
    logic [1:0]  m_exp = '0;
    bit          m_live = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit needs_port(input ent_t e);
        return e.we && (e.addr != 5'd0);
    endfunction

    // Outputs predicted from the queue contents and current inputs
    task automatic compare_all();
        logic        e_we, e_rv, e_hit;
        logic [4:0]  e_addr;
        logic [63:0] e_data, e_fdata;
        logic [1:0]  e_pid;
        e_we = 0; e_rv = 0; e_hit = 0; e_addr = 0; e_data = 0; e_fdata = 0; e_pid = 0;
        if (q.size() > 0) begin
            e_addr = q[0].addr;
            e_data = q[0].data;
            e_pid  = q[0].pid;
            if (!reset_n) begin
                e_we = needs_port(q[0]);
                e_rv = !needs_port(q[0]) || wbReady_i;
            end
        end
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (needs_port(q[k]) && q[k].addr == fwdAddr_i) begin
                e_hit = 1'b1;
                e_fdata = q[k].data;
                break;
            end
        end
        chk("ready", 64'(ready_o), 64'(q.size() < DEPTH));
        chk("wb_we", 64'(wbWriteEnable_o), 64'(e_we));
        chk("wb_addr", 64'(wbAddr_o), 64'(e_addr));
        chk("wb_data", wbData_o, e_data);
        chk("ret_valid", 64'(retireValid_o), 64'(e_rv));
        chk("ret_pid", 64'(retirePID_o), 64'(e_pid));
        chk("fwd_hit", 64'(fwdHit_o), 64'(e_hit));
        chk("fwd_data", fwdData_o, e_fdata);
        chk("ret_count", 64'(retireCount_o), 64'(m_cnt));
        chk("pid_err", 64'(pidError_o), 64'(m_err));
    endtask

    task automatic drive(input bit r, input bit v, input bit we, input logic [4:0] a,
                         input logic [63:0] d, input logic [1:0] p, input bit wr,
                         input logic [4:0] fa);
        reset_n = r; valid_i = v; rdWriteEnable_i = we; rdAddr_i = a;
        rdData_i = d; way0_pID_i = p; wbReady_i = wr; fwdAddr_i = fa;
        #1;
        if (m_live) compare_all();
    endtask

    task automatic tick();
        bit   push, pop;
        ent_t e;
        @(posedge clk);
        if (reset_n) begin
            q.delete();
            m_cnt = '0; m_err = 1'b0; m_exp = '0;
            m_live = 1'b1;
        end else begin
            push = valid_i && (q.size() < DEPTH);
            pop  = (q.size() > 0) && (!needs_port(q[0]) || wbReady_i);
            if (pop) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (push) begin
                if (way0_pID_i != m_exp) m_err = 1'b1;
                m_exp = way0_pID_i + 2'd1;
                e.we = rdWriteEnable_i; e.addr = rdAddr_i; e.data = rdData_i; e.pid = way0_pID_i;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input bit wr, input logic [4:0] fa);
        drive(0, 0, 0, 5'd0, 64'd0, 2'd0, wr, fa);
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        idle(1, 0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_count", 64'(retireCount_o), 64'd0);
        chk("rst_fwd", 64'(fwdHit_o), 64'd0);

        // Single result, writes the next cycle
        drive(0, 1, 1, 5'd5, 64'h1234, 2'd0, 1, 0); tick();
        idle(1, 0);
        chk("single_we", 64'(wbWriteEnable_o), 64'd1);
        chk("single_addr", 64'(wbAddr_o), 64'd5);
        chk("single_data", wbData_o, 64'h1234);
        tick();
        idle(1, 0);
        chk("single_count", 64'(retireCount_o), 64'd1);
        chk("single_pid_err", 64'(pidError_o), 64'd0);

        // Three back-to-back results with the port stalled
        drive(0, 1, 1, 5'd1, 64'd11, 2'd1, 0, 0); tick();
        drive(0, 1, 1, 5'd2, 64'd22, 2'd2, 0, 0); tick();
        drive(0, 1, 1, 5'd3, 64'd33, 2'd3, 0, 0);
        chk("full_ready", 64'(ready_o), 64'd0);
        tick();
        drive(0, 1, 1, 5'd3, 64'd33, 2'd3, 1, 0);
        chk("drain_ready_low", 64'(ready_o), 64'd0);
        chk("drain_addr1", 64'(wbAddr_o), 64'd1);
        tick();
        drive(0, 1, 1, 5'd3, 64'd33, 2'd3, 1, 0);
        chk("drain_addr2", 64'(wbAddr_o), 64'd2);
        tick();
        idle(1, 0);
        chk("drain_addr3", 64'(wbData_o), 64'd33);
        tick();
        idle(1, 0);
        chk("drain_count", 64'(retireCount_o), 64'd4);

        // x0 destination retires without the port
        drive(0, 1, 1, 5'd0, 64'h55, 2'd0, 0, 0); tick();
        idle(0, 0);
        chk("x0_we", 64'(wbWriteEnable_o), 64'd0);
        chk("x0_retire", 64'(retireValid_o), 64'd1);
        tick();

        // Forwarding picks the youngest write
        drive(0, 1, 1, 5'd7, 64'hA, 2'd1, 0, 5'd7); tick();
        drive(0, 1, 1, 5'd7, 64'hB, 2'd2, 0, 5'd7);
        chk("fwd_excl_incoming", fwdData_o, 64'hA);
        tick();
        idle(0, 5'd7);
        chk("fwd_hit", 64'(fwdHit_o), 64'd1);
        chk("fwd_young", fwdData_o, 64'hB);
        idle(0, 5'd0);
        chk("fwd_x0", 64'(fwdHit_o), 64'd0);
        idle(1, 0); tick();
        idle(1, 0); tick();

        // pID sequence 0,1,3,0
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 5'd1, 64'd1, 2'd0, 1, 0); tick();
        drive(0, 1, 1, 5'd1, 64'd2, 2'd1, 1, 0); tick();
        drive(0, 1, 1, 5'd1, 64'd3, 2'd3, 1, 0); tick();
        idle(1, 0);
        chk("pid_err_set", 64'(pidError_o), 64'd1);
        drive(0, 1, 1, 5'd1, 64'd4, 2'd0, 1, 0); tick();
        idle(1, 0); tick();
        idle(1, 0);
        chk("pid_err_sticky", 64'(pidError_o), 64'd1);
        drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
        idle(1, 0);
        chk("pid_err_clear", 64'(pidError_o), 64'd0);

        // Retire counter wrap
        force dut.r_retire_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFE;
        drive(0, 1, 1, 5'd9, 64'd1, 2'd0, 1, 0); tick();
        drive(0, 1, 1, 5'd9, 64'd2, 2'd1, 1, 0); tick();
        idle(1, 0);
        chk("cnt_ffff", 64'(retireCount_o), 64'hFFFF_FFFF);
        tick();
        idle(1, 0);
        chk("cnt_wrap", 64'(retireCount_o), 64'd0);

        // Reset with two buffered entries
        drive(0, 1, 1, 5'd4, 64'd7, 2'd2, 0, 0); tick();
        drive(0, 1, 1, 5'd6, 64'd8, 2'd3, 0, 0); tick();
        drive(1, 1, 1, 5'd6, 64'd9, 2'd0, 1, 5'd4);
        chk("rst_no_write", 64'(wbWriteEnable_o), 64'd0);
        tick();
        idle(1, 5'd4);
        chk("rst_empty_ready", 64'(ready_o), 64'd1);
        chk("rst_empty_ret", 64'(retireValid_o), 64'd0);
        chk("rst_cnt0", 64'(retireCount_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit         r, v, we, wr;
            logic [4:0] a;
            logic [1:0] p;
            int         wr_pct;
            wr_pct = ((i / 300) % 3 == 0) ? 90 : (((i / 300) % 3 == 1) ? 50 : 10);
            r  = ($urandom_range(0, 249) == 0);
            v  = ($urandom_range(0, 99) < 70);
            we = ($urandom_range(0, 99) < 80);
            wr = ($urandom_range(0, 99) < wr_pct);
            a  = 5'($urandom_range(0, 7));
            p  = ($urandom_range(0, 19) == 0) ? 2'($urandom) : m_exp;
            drive(r, v, we, a, {$urandom, $urandom}, p, wr, 5'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
